// File: rtl/mac_accumulator_if.sv
// Product-in / result-out bundle for the MAC accumulator.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid=1 and ready=1 in the cycle before that edge. Once a
// producer raises valid it holds valid and its data stable until the transfer
// completes. ready may be raised or dropped freely and does not depend on
// valid. Here the block is the consumer of prod_* and the producer of res_*.
// state_dbg mirrors the block's FSM (0 = ACCUM, 1 = HOLD) for observation.
interface mac_accumulator_if #(
  parameter int ACC_W = 20
);
  logic             prod_valid;
  logic [15:0]      prod_data;
  logic             prod_last;
  logic             prod_ready;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_ovf;
  logic             state_dbg;

  // Accumulator side.
  modport slave (
    input  prod_valid, prod_data, prod_last, res_ready,
    output prod_ready, res_valid, res_data, res_ovf, state_dbg
  );

  // Upstream multiplier / downstream consumer side.
  modport master (
    output prod_valid, prod_data, prod_last, res_ready,
    input  prod_ready, res_valid, res_data, res_ovf, state_dbg
  );
endinterface

// File: rtl/mac_accumulator.sv
// Saturating dot-product accumulator. Sums unsigned 16-bit products until a
// beat marked last (or MAX_TERMS beats) arrives, then holds the sum until the
// consumer takes it. clear aborts whatever is in progress.
module mac_accumulator #(
  parameter int ACC_W     = 20,
  parameter int MAX_TERMS = 16,
  localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  mac_accumulator_if.slave bus,
  output logic [CNT_W-1:0] term_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_inc;

  // Accept only while accumulating; the extra sum bit is the carry that
  // signals saturation.
  assign accept  = bus.prod_valid && (state == ACCUM);
  assign sum     = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, bus.prod_data};
  assign cnt_inc = cnt + 1'b1;

  // State register and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and datapath update; clear overrides any beat or handshake.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            // A carry out means the true sum no longer fits: pin to all-ones.
            // An already saturated acc carries on any non-zero add and stays pinned.
            acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            ovf_nxt = ovf | sum[ACC_W];
            cnt_nxt = cnt_inc;
            if (bus.prod_last || (cnt_inc == MAX_CNT)) begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ACCUM;
        end
      endcase
    end
  end

  // Handshake outputs decode straight from state; result fields are the registers.
  always_comb begin
    bus.prod_ready = (state == ACCUM);
    bus.res_valid  = (state == HOLD);
    bus.res_data   = acc;
    bus.res_ovf    = ovf;
    bus.state_dbg  = state;
    term_cnt       = cnt;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ACC_W, 20, accumulator/result width in bits; legal range 16..32.
- MAX_TERMS, 16, products per dot product before a forced result; legal range 2..256.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- clear, in, 1, synchronous abort/flush.
- prod_valid, in, 1, a product beat is offered.
- prod_data, in, 16, unsigned 8x8 product from the upstream multiplier.
- prod_last, in, 1, the offered beat is the final term.
- prod_ready, out, 1, block can accept a beat.
- res_valid, out, 1, result is held.
- res_ready, in, 1, consumer accepts the result.
- res_data, out, ACC_W, accumulated sum.
- res_ovf, out, 1, saturation occurred during this sum.
- term_cnt, out, $clog2(MAX_TERMS+1), terms accepted in the current sum.

Function
REQ-003 The block SHALL have two states: ACCUM and HOLD. It SHALL enter ACCUM on reset.

REQ-004 In ACCUM, prod_ready SHALL be 1 and res_valid SHALL be 0.
- In HOLD, prod_ready SHALL be 0 and res_valid SHALL be 1.
- Both outputs SHALL be registered or decoded directly from state, with no combinational path from inputs.

REQ-005 A beat SHALL be accepted only in a cycle where prod_valid=1 and prod_ready=1.
- prod_data and prod_last SHALL be ignored in all other cycles.

REQ-006 On acceptance, the accumulator SHALL become acc + zero-extended prod_data, and term_cnt SHALL increment by 1.

REQ-007 Saturation rule:
- If the true sum exceeds 2^ACC_W-1, acc SHALL become all-ones and res_ovf SHALL set.
- res_ovf is sticky until the result is consumed, cleared, or reset.
- Further additions to a saturated acc SHALL leave it all-ones.

REQ-008 Transition ACCUM to HOLD:
- Triggered when the accepted beat has prod_last=1, or when it makes term_cnt equal MAX_TERMS.
- res_valid SHALL assert in the cycle after that beat is accepted (latency 1).
- res_data SHALL include that beat.

REQ-009 In HOLD, res_data, res_ovf and term_cnt SHALL remain stable while res_ready=0.

REQ-010 Transition HOLD to ACCUM:
- Triggered by a cycle with res_valid=1 and res_ready=1.
- On the next edge, acc, res_ovf and term_cnt SHALL clear to 0 and state SHALL be ACCUM.
- The first new beat can be accepted one cycle after the handshake.

REQ-011 res_data SHALL always show the current accumulator value, including partial sums during ACCUM. It is qualified only by res_valid.

REQ-012 clear=1 SHALL take priority over every other event in the same cycle:
- Next state is ACCUM; acc, res_ovf and term_cnt are 0.
- Any beat offered in that cycle is discarded (not accumulated), even though prod_ready=1.
- Any held result is dropped without a handshake.

REQ-013 A beat with prod_last=1 and prod_data=0 SHALL still count as a term and produce a result.
- A result with term_cnt=1 SHALL be legal.

REQ-014 No sum SHALL ever contain zero terms; HOLD is entered only via an accepted beat.

Reset
REQ-015 When rst_n=0, the block SHALL immediately, without waiting for clk, force:
- state = ACCUM
- acc = 0 and res_data = 0
- res_ovf = 0
- term_cnt = 0
- res_valid = 0
- prod_ready = 1 (as decoded from ACCUM)

REQ-016 Reset asserted mid-sum or in HOLD SHALL discard all partial or held results. On release, the block SHALL accept a beat at the first rising edge with rst_n=1.

Verification
REQ-017 Basic sum: beats 255*255=65025, 3, 10 (last=1), with res_ready=1 -> res_valid pulses one cycle after the last beat; res_data=65038, term_cnt=3, res_ovf=0.

REQ-018 Forced result: 16 beats of 65025 with prod_last=0 -> HOLD after the 16th beat; res_data=1040400, term_cnt=16, and a 17th beat is not accepted (prod_ready=0).

REQ-019 Saturation (ACC_W=16): beats 60000 then 10000 (last=1) -> res_data=65535, res_ovf=1. The next sum, 5 (last=1), gives res_data=5, res_ovf=0.

REQ-020 Backpressure: result 1234 held with res_ready=0 for 5 cycles -> res_data stable, prod_ready=0 throughout. Raising res_ready gives a handshake, and the next cycle shows res_valid=0, prod_ready=1, term_cnt=0.

REQ-021 Clear collision: clear=1 in the same cycle as an accepted beat of 500 -> next cycle acc=0, term_cnt=0. A following beat 7 (last=1) gives res_data=7.

REQ-022 Async reset: assert rst_n=0 mid-cycle during HOLD -> res_valid=0 and res_data=0 before the next clk edge. After release, beat 9 (last=1) gives res_data=9.
